barrel_shifter: RTL and testbench

Registered, parameterisable barrel shifter/rotator for datapath operand alignment. Accepts a WIDTH-bit word, a shift amount, a direction and a mode. Produces the shifted word one clock later, with a valid flag. Built as log2(WIDTH) mux stages (shift by 1, 2, 4, …) feeding a single output register.

---
 rtl/barrel_shifter.sv | 112 +++++++++++
 tb/tb_barrel_shifter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/barrel_shifter.sv
// -----------------------------------------------------------------------------
// barrel_shifter
//
// Registered barrel shifter / rotator for datapath operand alignment.
// A WIDTH-bit word is shifted or rotated by 0..WIDTH-1 positions through
// log2(WIDTH) mux stages. Stage k moves the word by 2^k positions when
// shift[k] is set. The result is captured in a single output register, so
// the latency is exactly one cycle, and a new operation can be issued every
// cycle.
//
// Handshake: in_valid qualifies data_in/shift/dir/mode at a rising edge of
// clk. There is no backpressure. out_valid is high for exactly the cycles
// that follow a captured input. When in_valid is low, data_out keeps its
// last result and the operand inputs are ignored.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset; overrides in_valid
//   in_valid   in   1        capture the operands at this edge
//   data_in    in   WIDTH    operand
//   shift      in   SHIFT_W  shift amount, 0..WIDTH-1
//   dir        in   1        0 = left (toward MSB), 1 = right (toward LSB)
//   mode       in   2        00 logical, 01 arithmetic, 1x rotate
//   data_out   out  WIDTH    registered result
//   out_valid  out  1        data_out holds the result of a captured input
// -----------------------------------------------------------------------------
module barrel_shifter #(
    parameter  int WIDTH   = 4,
    localparam int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               dir,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   data_out,
    output logic               out_valid
);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] vac_mask;
    logic [WIDTH-1:0] fill;
    logic             is_rot;
    logic             sign_fill;

    // Mux stages. Each active stage starts from a rotation of the current
    // word. vac_mask marks the bit positions the shift vacates. A rotate
    // keeps the wrapped bits in those positions. Otherwise the vacated bits
    // get zeros or, for an arithmetic right shift, the sign bit. The sign bit
    // survives every stage, so data_in's MSB is used directly as the fill.
    always_comb begin
        result    = data_in;
        rot       = '0;
        vac_mask  = '0;
        fill      = '0;
        is_rot    = mode[1];
        sign_fill = dir && (mode == 2'b01) && data_in[WIDTH-1];
        for (int k = 0; k < SHIFT_W; k++) begin
            if (shift[k]) begin
                if (!dir) begin
                    rot      = (result << (1 << k)) | (result >> (WIDTH - (1 << k)));
                    vac_mask = ~(ONES << (1 << k));
                end else begin
                    rot      = (result >> (1 << k)) | (result << (WIDTH - (1 << k)));
                    vac_mask = ~(ONES >> (1 << k));
                end
                if (is_rot) begin
                    fill = rot & vac_mask;
                end else if (sign_fill) begin
                    fill = vac_mask;
                end else begin
                    fill = '0;
                end
                result = (rot & ~vac_mask) | fill;
            end
        end
    end

    // Output register next-state: hold data when idle so that idle-cycle
    // operand values (including X) never reach data_out.
    always_comb begin
        data_out_d  = data_out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            data_out_d = result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter
//
// Directed bench for barrel_shifter at WIDTH = 4. Operands are driven on the
// falling edge and outputs are checked 1 ns after the following rising edge.
// Every expected value is written by hand from the operation's definition.
// -----------------------------------------------------------------------------
module tb_barrel_shifter;

    localparam int WIDTH   = 4;
    localparam int SHIFT_W = 2;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic [WIDTH-1:0]   data_in;
    logic [SHIFT_W-1:0] shift;
    logic               dir;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   data_out;
    logic               out_valid;

    int checks;
    int errors;

    barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .shift     (shift),
        .dir       (dir),
        .mode      (mode),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then check both outputs.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [WIDTH-1:0] d, input logic [SHIFT_W-1:0] s,
                        input logic dr, input logic [1:0] m,
                        input logic [WIDTH-1:0] exp_data, input logic exp_valid);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        data_in  = d;
        shift    = s;
        dir      = dr;
        mode     = m;
        @(posedge clk);
        #1;
        chk({tag, ".data"}, data_out, exp_data);
        chk({tag, ".valid"}, {3'b000, out_valid}, {3'b000, exp_valid});
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        shift    = '0;
        dir      = 1'b0;
        mode     = 2'b00;

        // Reset held two cycles while a valid operand is offered.
        step("rst0", 1, 1, 4'b1111, 2'd1, 0, 2'b10, 4'b0000, 0);
        step("rst1", 1, 1, 4'b1111, 2'd1, 0, 2'b10, 4'b0000, 0);

        // Rotate left
        step("rol_1011_s0", 0, 1, 4'b1011, 2'd0, 0, 2'b10, 4'b1011, 1);
        step("rol_1011_s1", 0, 1, 4'b1011, 2'd1, 0, 2'b10, 4'b0111, 1);
        step("rol_1011_s2", 0, 1, 4'b1011, 2'd2, 0, 2'b10, 4'b1110, 1);
        step("rol_1011_s3", 0, 1, 4'b1011, 2'd3, 0, 2'b10, 4'b1101, 1);
        step("rol_1100_s0", 0, 1, 4'b1100, 2'd0, 0, 2'b10, 4'b1100, 1);
        step("rol_1100_s1", 0, 1, 4'b1100, 2'd1, 0, 2'b10, 4'b1001, 1);
        step("rol_1100_s2", 0, 1, 4'b1100, 2'd2, 0, 2'b11, 4'b0011, 1);
        step("rol_1100_s3", 0, 1, 4'b1100, 2'd3, 0, 2'b11, 4'b0110, 1);

        // Rotate right
        step("ror_1011_s1", 0, 1, 4'b1011, 2'd1, 1, 2'b10, 4'b1101, 1);
        step("ror_1011_s2", 0, 1, 4'b1011, 2'd2, 1, 2'b11, 4'b1110, 1);
        step("ror_1011_s3", 0, 1, 4'b1011, 2'd3, 1, 2'b10, 4'b0111, 1);

        // Logical
        step("lsl_1011_s1", 0, 1, 4'b1011, 2'd1, 0, 2'b00, 4'b0110, 1);
        step("lsl_1011_s2", 0, 1, 4'b1011, 2'd2, 0, 2'b00, 4'b1100, 1);
        step("lsl_1011_s3", 0, 1, 4'b1011, 2'd3, 0, 2'b00, 4'b1000, 1);
        step("lsr_1011_s1", 0, 1, 4'b1011, 2'd1, 1, 2'b00, 4'b0101, 1);
        step("lsr_1011_s2", 0, 1, 4'b1011, 2'd2, 1, 2'b00, 4'b0010, 1);
        step("lsr_1011_s3", 0, 1, 4'b1011, 2'd3, 1, 2'b00, 4'b0001, 1);

        // Arithmetic
        step("asr_1011_s1", 0, 1, 4'b1011, 2'd1, 1, 2'b01, 4'b1101, 1);
        step("asr_1011_s2", 0, 1, 4'b1011, 2'd2, 1, 2'b01, 4'b1110, 1);
        step("asr_1011_s3", 0, 1, 4'b1011, 2'd3, 1, 2'b01, 4'b1111, 1);
        step("asr_0110_s1", 0, 1, 4'b0110, 2'd1, 1, 2'b01, 4'b0011, 1);
        step("asl_1011_s1", 0, 1, 4'b1011, 2'd1, 0, 2'b01, 4'b0110, 1);
        step("asr_1011_s0", 0, 1, 4'b1011, 2'd0, 1, 2'b01, 4'b1011, 1);
        step("lsr_1011_s0", 0, 1, 4'b1011, 2'd0, 1, 2'b00, 4'b1011, 1);

        // Valid/hold: three back-to-back operations, then idle with
        // changing (and unknown) operands.
        step("b2b_0", 0, 1, 4'b0001, 2'd1, 0, 2'b00, 4'b0010, 1);
        step("b2b_1", 0, 1, 4'b0001, 2'd2, 0, 2'b00, 4'b0100, 1);
        step("b2b_2", 0, 1, 4'b0001, 2'd3, 0, 2'b00, 4'b1000, 1);
        step("idle_0", 0, 0, 4'b0111, 2'd1, 1, 2'b10, 4'b1000, 0);
        step("idle_1", 0, 0, 4'b1110, 2'd2, 0, 2'b01, 4'b1000, 0);
        step("idle_x", 0, 0, 4'bxxxx, 2'bxx, 1'bx, 2'bxx, 4'b1000, 0);

        // Mid-stream reset clears outputs on that edge.
        step("pre_rst", 0, 1, 4'b0101, 2'd1, 0, 2'b10, 4'b1010, 1);
        step("mid_rst", 1, 1, 4'b1111, 2'd1, 0, 2'b00, 4'b0000, 0);
        step("post_rst", 0, 1, 4'b0011, 2'd3, 1, 2'b10, 4'b0110, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
